mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
MEM-stage controller at the consuming end of the EX/MEM pipeline register. It takes the EX/MEM control and data bundle and drives a multi-cycle data memory over a req/gnt/rvalid handshake. While an access is outstanding it stalls the upstream pipeline. It also owns the MEM/WB pipeline register that feeds write-back.

Parameters:
N, 64, datapath width (address, store data, load data, ALU result)
TIMEOUT, 255, max cycles spent in REQ or WAIT before abandoning the access

Ports:
clk  in  1  clock
rst  in  1  reset
valid_in  in  1  EX/MEM slot holds a real instruction
memWrite_in  in  1  store
memRead_in  in  1  load
memToReg_in  in  1  WB selects load data
regWrite_in  in  1  WB writes register file
writeReg_in  in  5  destination register
ALUResult_in  in  N  ALU result / memory address
writeDataMem_in  in  N  store data
stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
dmem_req  out  1  memory request
dmem_we  out  1  1 = write
dmem_addr  out  N  address
dmem_wdata  out  N  store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  read data valid
dmem_rdata  in  N  read data
valid_wb  out  1  MEM/WB slot valid
memToReg_wb  out  1  registered memToReg
regWrite_wb  out  1  registered regWrite (gated)
writeReg_wb  out  5  registered destination
ALUResult_wb  out  N  registered ALU result
readData_wb  out  N  registered load data
bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset: state=IDLE, all outputs 0, timeout counter 0.
- States: IDLE, REQ, WAIT, DONE.
- Let mem_op = valid_in & (memRead_in | memWrite_in). If both read and write are set, treat the op as a write.
- IDLE, no mem_op: MEM/WB loads the inputs at the next edge (1-cycle latency), readData_wb=0, stall=0.
- IDLE, mem_op: stall=1 combinationally. At the edge, capture we/addr/wdata into internal regs and go to REQ. MEM/WB loads a bubble (valid_wb=0, regWrite_wb=0).
- REQ: dmem_req=1; dmem_we, dmem_addr and dmem_wdata come from the captured regs and stay stable until gnt. stall=1.
  - On dmem_gnt with a write, go to DONE.
  - On dmem_gnt with a read, go to WAIT; dmem_req drops the next cycle.
- WAIT: dmem_req=0, stall=1. On dmem_rvalid, capture dmem_rdata and go to DONE. An rvalid arriving in any other state is ignored.
- DONE: stall=0. At the edge, MEM/WB loads the EX/MEM inputs, which are still held, plus the captured rdata (0 for stores); return to IDLE. The held mem_op is not re-detected in DONE.
- Minimum latency from entering IDLE with the op to MEM/WB load: store 3 cycles, load 4 cycles.
- While stall=1, MEM/WB receives bubbles every cycle, so write-back never repeats.
- Timeout:
  - The counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT, set bus_err (stays set until rst) and go to DONE.
  - The resulting MEM/WB entry has valid_wb=1, regWrite_wb=0, readData_wb=0.
- Reset mid-access: the state returns to IDLE and dmem_req=0 on the next cycle. The memory must tolerate an abandoned request.
- Widths: dmem_addr = ALUResult_in captured unchanged. No alignment checks.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE, REQ, WAIT, DONE) and REG_ADDR_W=5.
- Sub-module buffer_MEMtoWB: plain synchronous-reset register for valid, memToReg, regWrite, writeReg, ALUResult, readData. Has a bubble-insert input.
- The FSM and timeout counter live in mem_stage_ctrl.

Test Plan:
- ALU op: valid_in=1, regWrite_in=1, writeReg_in=5, ALUResult_in=0x2A, no mem bits.
  -> Next cycle valid_wb=1, writeReg_wb=5, ALUResult_wb=0x2A, readData_wb=0; stall never high.
- Store to 0x100, data 0xDEAD, gnt in the first REQ cycle.
  -> dmem_req=1 and dmem_we=1 for exactly 1 cycle; stall high 2 cycles; MEM/WB loads in cycle 3 with regWrite_wb=0.
- Load from 0x80, gnt after 2 cycles, rvalid 3 cycles later with 0x1234.
  -> addr stable through REQ; stall high until DONE; readData_wb=0x1234, memToReg_wb=1; bubbles before that.
- Load, gnt, rvalid never arrives, TIMEOUT=8.
  -> After 8 WAIT-related cycles bus_err=1, MEM/WB valid_wb=1 with regWrite_wb=0; bus_err stays 1 until rst.
- rst asserted for 1 cycle during WAIT.
  -> Next cycle state=IDLE, all outputs 0, bus_err=0; a later rvalid is ignored.
- Load followed immediately by an ALU op.
  -> The ALU op waits in EX/MEM; MEM/WB shows the load, then the ALU op on the following cycle; no duplicate write-back.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: controller state encoding and register-file address width.
package mem_stage_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/buffer_MEMtoWB.sv
// MEM/WB pipeline register; a bubble loads an all-zero (invalid, no-write) entry.
module buffer_MEMtoWB
  import mem_stage_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  valid_in,
  input  logic                  memToReg_in,
  input  logic                  regWrite_in,
  input  logic [REG_ADDR_W-1:0] writeReg_in,
  input  logic [N-1:0]          ALUResult_in,
  input  logic [N-1:0]          readData_in,
  output logic                  valid_wb,
  output logic                  memToReg_wb,
  output logic                  regWrite_wb,
  output logic [REG_ADDR_W-1:0] writeReg_wb,
  output logic [N-1:0]          ALUResult_wb,
  output logic [N-1:0]          readData_wb
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      valid_wb     <= 1'b0;
      memToReg_wb  <= 1'b0;
      regWrite_wb  <= 1'b0;
      writeReg_wb  <= '0;
      ALUResult_wb <= '0;
      readData_wb  <= '0;
    end else begin
      valid_wb     <= valid_in;
      memToReg_wb  <= memToReg_in;
      regWrite_wb  <= regWrite_in;
      writeReg_wb  <= writeReg_in;
      ALUResult_wb <= ALUResult_in;
      readData_wb  <= readData_in;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs data-memory accesses over req/gnt/rvalid, stalls upstream
// while an access is outstanding, and feeds the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int unsigned N       = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic                  memWrite_in,
  input  logic                  memRead_in,
  input  logic                  memToReg_in,
  input  logic                  regWrite_in,
  input  logic [REG_ADDR_W-1:0] writeReg_in,
  input  logic [N-1:0]          ALUResult_in,
  input  logic [N-1:0]          writeDataMem_in,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [N-1:0]          dmem_addr,
  output logic [N-1:0]          dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [N-1:0]          dmem_rdata,
  output logic                  valid_wb,
  output logic                  memToReg_wb,
  output logic                  regWrite_wb,
  output logic [REG_ADDR_W-1:0] writeReg_wb,
  output logic [N-1:0]          ALUResult_wb,
  output logic [N-1:0]          readData_wb,
  output logic                  bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  logic [CNT_W-1:0] to_cnt;
  logic             err_pend;
  logic [N-1:0]     rdata_q;
  logic             mem_op;
  logic             timeout_hit;
  logic             wb_regwrite;
  logic [N-1:0]     wb_rdata;

  assign mem_op      = valid_in & (memRead_in | memWrite_in);
  assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT - 1));
  assign stall       = (state == REQ) || (state == WAIT) || ((state == IDLE) && mem_op);

  // A timed-out access still retires, but must not write the register file.
  assign wb_regwrite = regWrite_in & ~((state == DONE) & err_pend);
  assign wb_rdata    = (state == DONE) ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      to_cnt     <= '0;
      err_pend   <= 1'b0;
      bus_err    <= 1'b0;
      rdata_q    <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= REQ;
            to_cnt     <= '0;
            err_pend   <= 1'b0;
            rdata_q    <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= memWrite_in;
            dmem_addr  <= ALUResult_in;
            dmem_wdata <= writeDataMem_in;
          end
        end
        REQ: begin
          to_cnt <= to_cnt + CNT_W'(1);
          if (dmem_gnt && dmem_we) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
          end else if (timeout_hit) begin
            state    <= DONE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            err_pend <= 1'b1;
            bus_err  <= 1'b1;
          end else if (dmem_gnt) begin
            state    <= WAIT;
            dmem_req <= 1'b0;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + CNT_W'(1);
          if (dmem_rvalid) begin
            state   <= DONE;
            rdata_q <= dmem_rdata;
          end else if (timeout_hit) begin
            state    <= DONE;
            err_pend <= 1'b1;
            bus_err  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  buffer_MEMtoWB #(.N(N)) u_mem_wb (
    .clk          (clk),
    .rst          (rst),
    .bubble       (stall),
    .valid_in     (valid_in),
    .memToReg_in  (memToReg_in),
    .regWrite_in  (wb_regwrite),
    .writeReg_in  (writeReg_in),
    .ALUResult_in (ALUResult_in),
    .readData_in  (wb_rdata),
    .valid_wb     (valid_wb),
    .memToReg_wb  (memToReg_wb),
    .regWrite_wb  (regWrite_wb),
    .writeReg_wb  (writeReg_wb),
    .ALUResult_wb (ALUResult_wb),
    .readData_wb  (readData_wb)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: acts as the upstream pipeline and the data memory, and
// scoreboards every MEM/WB entry against what the issued instruction should retire as.
module tb_mem_stage_ctrl;

  localparam int unsigned N       = 64;
  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic        v;
    logic        mtr;
    logic        rw;
    logic [4:0]  wr;
    logic [63:0] alu;
    logic [63:0] rd;
  } wb_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, memWrite_in, memRead_in, memToReg_in, regWrite_in;
  logic [4:0]    writeReg_in;
  logic [N-1:0]  ALUResult_in, writeDataMem_in;
  logic          stall, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [N-1:0]  dmem_addr, dmem_wdata, dmem_rdata;
  logic          valid_wb, memToReg_wb, regWrite_wb, bus_err;
  logic [4:0]    writeReg_wb;
  logic [N-1:0]  ALUResult_wb, readData_wb;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  mem_stage_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_in        (valid_in),
    .memWrite_in     (memWrite_in),
    .memRead_in      (memRead_in),
    .memToReg_in     (memToReg_in),
    .regWrite_in     (regWrite_in),
    .writeReg_in     (writeReg_in),
    .ALUResult_in    (ALUResult_in),
    .writeDataMem_in (writeDataMem_in),
    .stall           (stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_gnt        (dmem_gnt),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .valid_wb        (valid_wb),
    .memToReg_wb     (memToReg_wb),
    .regWrite_wb     (regWrite_wb),
    .writeReg_wb     (writeReg_wb),
    .ALUResult_wb    (ALUResult_wb),
    .readData_wb     (readData_wb),
    .bus_err         (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Compare the current MEM/WB contents against the scoreboard head.
  task automatic check_wb();
    wb_t e;
    if (valid_wb) begin
      if (sb.size() == 0) begin
        check("wb_unexpected_entry", 64'(valid_wb), 64'd0);
      end else begin
        e = sb.pop_front();
        check("wb_memToReg", 64'(memToReg_wb), 64'(e.mtr));
        check("wb_regWrite", 64'(regWrite_wb), 64'(e.rw));
        check("wb_writeReg", 64'(writeReg_wb), 64'(e.wr));
        check("wb_ALUResult", ALUResult_wb, e.alu);
        check("wb_readData", readData_wb, e.rd);
      end
    end else begin
      check("wb_bubble_regWrite", 64'(regWrite_wb), 64'd0);
    end
  endtask

  // Present one EX/MEM instruction, hold it while stalled, and play the memory side.
  // rv_dly < 0 means the memory never returns read data.
  task automatic issue(input logic v, input logic we, input logic re, input logic mtr,
                       input logic rw, input logic [4:0] wreg, input logic [63:0] alu,
                       input logic [63:0] wdat, input int g_dly, input int rv_dly,
                       input logic [63:0] rdat);
    int   stall_n = 0;
    int   req_n = 0;
    int   rv_timer = 0;
    int   exp_stall;
    logic rv_armed = 1'b0;
    logic done = 1'b0;
    logic memop;
    logic is_load;
    wb_t  e;
    memop   = v && (we || re);
    is_load = memop && !we;
    @(negedge clk);
    valid_in = v; memWrite_in = we; memRead_in = re; memToReg_in = mtr;
    regWrite_in = rw; writeReg_in = wreg; ALUResult_in = alu; writeDataMem_in = wdat;
    if (v) begin
      e.v   = 1'b1;
      e.mtr = mtr;
      e.rw  = rw && !(is_load && rv_dly < 0);
      e.wr  = wreg;
      e.alu = alu;
      e.rd  = (is_load && rv_dly >= 0) ? rdat : 64'd0;
      sb.push_back(e);
    end
    exp_stall = !memop ? 0 : we ? g_dly + 2 : (rv_dly < 0) ? int'(TIMEOUT) + 1 : g_dly + rv_dly + 3;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check_wb();
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      if (rv_armed) begin
        if (rv_timer == 0) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdat;
          rv_armed    = 1'b0;
        end else begin
          rv_timer--;
        end
      end
      dmem_gnt = 1'b0;
      if (dmem_req) begin
        check("req_addr", dmem_addr, alu);
        check("req_we", 64'(dmem_we), 64'(we));
        if (we) check("req_wdata", dmem_wdata, wdat);
        if (req_n == g_dly) begin
          dmem_gnt = 1'b1;
          if (!we && rv_dly >= 0) begin
            rv_armed = 1'b1;
            rv_timer = rv_dly;
          end
        end
        req_n++;
      end
      #1;
      if (stall) stall_n++;
      else done = 1'b1;
    end
    if (!done) check("accept_bound", 64'd0, 64'd1);
    check("stall_cycles", 64'(stall_n), 64'(exp_stall));
    if (memop) check("req_cycles", 64'(req_n), 64'(g_dly + 1));
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 0; memWrite_in = 0; memRead_in = 0; memToReg_in = 0; regWrite_in = 0;
    writeReg_in = '0; ALUResult_in = '0; writeDataMem_in = '0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valid_wb", 64'(valid_wb), 64'd0);
    check("rst_dmem_req", 64'(dmem_req), 64'd0);
    check("rst_bus_err", 64'(bus_err), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    // ALU op, store, load, then an ALU op right behind the load
    issue(1, 0, 0, 0, 1, 5'd5, 64'h2A, 64'h0, 0, 0, 64'h0);
    issue(1, 1, 0, 0, 0, 5'd0, 64'h100, 64'hDEAD, 0, 0, 64'h0);
    issue(1, 0, 1, 1, 1, 5'd3, 64'h80, 64'h0, 2, 2, 64'h1234);
    issue(1, 0, 0, 0, 1, 5'd6, 64'h55, 64'h0, 0, 0, 64'h0);
    // read+write together behaves as a store; store with delayed grant
    issue(1, 1, 1, 0, 0, 5'd0, 64'h208, 64'hBEEF, 1, 0, 64'h0);
    issue(1, 0, 1, 1, 1, 5'd11, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 0, 0, 64'hCAFE_F00D_0000_0001);
    check("bus_err_before_timeout", 64'(bus_err), 64'd0);

    // Load whose data never arrives
    issue(1, 0, 1, 1, 1, 5'd9, 64'h300, 64'h0, 0, -1, 64'h0);
    issue(1, 0, 0, 0, 1, 5'd4, 64'h77, 64'h0, 0, 0, 64'h0);
    check("bus_err_sticky", 64'(bus_err), 64'd1);
    issue(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0, 64'h0);
    issue(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0, 64'h0);
    check("bus_err_still_set", 64'(bus_err), 64'd1);

    // Reset while a load is in WAIT
    @(negedge clk);
    valid_in = 1; memRead_in = 1; memWrite_in = 0; memToReg_in = 1; regWrite_in = 1;
    writeReg_in = 5'd7; ALUResult_in = 64'h40;
    @(negedge clk);
    check("midrst_req", 64'(dmem_req), 64'd1);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    check("midrst_wait_stall", 64'(stall), 64'd1);
    check("midrst_wait_req", 64'(dmem_req), 64'd0);
    rst = 1'b1;
    valid_in = 0; memRead_in = 0; memToReg_in = 0; regWrite_in = 0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_req_after", 64'(dmem_req), 64'd0);
    check("midrst_bus_err", 64'(bus_err), 64'd0);
    check("midrst_valid_wb", 64'(valid_wb), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h9999;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    check("late_rvalid_valid_wb", 64'(valid_wb), 64'd0);
    check("late_rvalid_readData", readData_wb, 64'd0);
    check("late_rvalid_stall", 64'(stall), 64'd0);

    // Normal operation resumes after the abandoned access
    issue(1, 0, 1, 1, 1, 5'd12, 64'h440, 64'h0, 0, 0, 64'h5A5A);
    issue(1, 0, 0, 0, 1, 5'd13, 64'h99, 64'h0, 0, 0, 64'h0);
    issue(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0, 64'h0);
    issue(0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 0, 0, 64'h0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
